// File: rtl/clock_set_controller_pkg.sv
// Shared types and default constants for the clock time-set sequencer.
// Optional feature macro: CLKSET_AUTOREPEAT_EN (adds the auto-repeat defaults).
package clock_set_controller_pkg;

  typedef enum logic [1:0] {
    ModeRun     = 2'd0,
    ModeSetHour = 2'd1,
    ModeSetMin  = 2'd2,
    ModeSetSec  = 2'd3
  } mode_t;

  localparam int unsigned DefDebounceCycles = 64;
  localparam int unsigned DefIdleTimeoutS   = 10;
`ifdef CLKSET_AUTOREPEAT_EN
  localparam int unsigned DefRepeatDelay    = 16384;
  localparam int unsigned DefRepeatPeriod   = 4096;
`endif

  // Mode button walks the set phases cyclically.
  function automatic mode_t next_mode(mode_t m);
    unique case (m)
      ModeRun:     next_mode = ModeSetHour;
      ModeSetHour: next_mode = ModeSetMin;
      ModeSetMin:  next_mode = ModeSetSec;
      ModeSetSec:  next_mode = ModeRun;
      default:     next_mode = ModeRun;
    endcase
  endfunction

endpackage

// File: rtl/clock_set_controller_if.sv
// Button/tick inputs and counter-chain/display outputs of the time-set sequencer.
interface clock_set_controller_if;

  logic       btn_mode_n;
  logic       btn_inc_n;
  logic       tick_1hz;
  logic       run_en;
  logic       inc_hour;
  logic       inc_min;
  logic       clr_sec;
  logic       blank_hour;
  logic       blank_min;
  logic [1:0] mode;

  modport master (
    input  btn_mode_n, btn_inc_n, tick_1hz,
    output run_en, inc_hour, inc_min, clr_sec, blank_hour, blank_min, mode
  );

  modport slave (
    output btn_mode_n, btn_inc_n, tick_1hz,
    input  run_en, inc_hour, inc_min, clr_sec, blank_hour, blank_min, mode
  );

endinterface

// File: rtl/clock_set_controller_btn_debounce.sv
// Active-low button conditioner: 2-flop synchroniser, stability counter, 1-cycle press pulse.
module clock_set_controller_btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic level,
  output logic press
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]      sync_q;
  logic            synced;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            level_q, level_d;
  logic            armed_q, armed_d;
  logic            press_q, press_d;

  // Synchroniser keeps sampling through reset so a held button is visible right after it.
  always_ff @(posedge clk) begin
    sync_q <= {sync_q[0], ~btn_n};
  end

  assign synced = sync_q[1];

  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (synced != level_q) begin
      if (cnt_q == CntW'(DEBOUNCE_CYCLES - 1)) begin
        level_d = synced;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
    // Presses count only once the pin has been seen released since reset.
    armed_d = armed_q | ~synced;
    press_d = armed_q & level_d & ~level_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
      armed_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      armed_q <= armed_d;
      press_q <= press_d;
    end
  end

  assign level = level_q & armed_q;
  assign press = press_q;

endmodule

// File: rtl/clock_set_controller.sv
// Time-set sequencer: set-mode FSM, idle timeout, blink phase and counter strobes.
// Optional feature macro: CLKSET_AUTOREPEAT_EN (held-inc auto-repeat in SET_HOUR/SET_MIN).
module clock_set_controller
  import clock_set_controller_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles,
  parameter int unsigned IDLE_TIMEOUT_S  = DefIdleTimeoutS
`ifdef CLKSET_AUTOREPEAT_EN
  ,
  parameter int unsigned REPEAT_DELAY    = DefRepeatDelay,
  parameter int unsigned REPEAT_PERIOD   = DefRepeatPeriod
`endif
) (
  input logic                    clk,
  input logic                    rst,
  clock_set_controller_if.master bus
);

  localparam int unsigned IdleW = $clog2(IDLE_TIMEOUT_S + 1);

  logic mode_ev, inc_ev, inc_level, rep_fire, activity;
  logic unused_mode_level;

  mode_t            mode_q, mode_d;
  logic [IdleW-1:0] idle_q, idle_d;
  logic             blink_q, blink_d;
  logic             inc_hour_q, inc_hour_d;
  logic             inc_min_q, inc_min_d;
  logic             clr_sec_q, clr_sec_d;

  clock_set_controller_btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db_mode (
    .clk  (clk),
    .rst  (rst),
    .btn_n(bus.btn_mode_n),
    .level(unused_mode_level),
    .press(mode_ev)
  );

  clock_set_controller_btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db_inc (
    .clk  (clk),
    .rst  (rst),
    .btn_n(bus.btn_inc_n),
    .level(inc_level),
    .press(inc_ev)
  );

`ifdef CLKSET_AUTOREPEAT_EN
  localparam int unsigned RepW = $clog2(REPEAT_DELAY + 1);

  logic [RepW-1:0] rep_q, rep_d;

  // Reloading to DELAY-PERIOD+1 makes later strobes land exactly PERIOD cycles apart.
  always_comb begin
    rep_d    = '0;
    rep_fire = 1'b0;
    if (inc_level && !mode_ev && (mode_q == ModeSetHour || mode_q == ModeSetMin)) begin
      if (rep_q == RepW'(REPEAT_DELAY)) begin
        rep_fire = 1'b1;
        rep_d    = RepW'(REPEAT_DELAY - REPEAT_PERIOD + 1);
      end else begin
        rep_d = rep_q + RepW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rep_q <= '0;
    end else begin
      rep_q <= rep_d;
    end
  end
`else
  logic unused_inc_level;
  assign unused_inc_level = inc_level;
  assign rep_fire         = 1'b0;
`endif

  always_comb begin
    mode_d     = mode_q;
    idle_d     = idle_q;
    blink_d    = blink_q;
    inc_hour_d = 1'b0;
    inc_min_d  = 1'b0;
    clr_sec_d  = 1'b0;
    activity   = 1'b0;

    // Mode press has priority; a coincident inc press is dropped.
    if (mode_ev) begin
      mode_d   = next_mode(mode_q);
      activity = 1'b1;
    end else if (inc_ev || rep_fire) begin
      activity = 1'b1;
      unique case (mode_q)
        ModeSetHour: inc_hour_d = 1'b1;
        ModeSetMin:  inc_min_d  = 1'b1;
        ModeSetSec:  clr_sec_d  = inc_ev;
        ModeRun:     activity   = 1'b0;
        default:     activity   = 1'b0;
      endcase
    end

    if (mode_d != mode_q || mode_q == ModeRun) begin
      idle_d  = '0;
      blink_d = 1'b0;
    end else begin
      if (bus.tick_1hz) begin
        blink_d = ~blink_q;
      end
      if (activity) begin
        idle_d = '0;
      end else if (bus.tick_1hz) begin
        if (idle_q >= IdleW'(IDLE_TIMEOUT_S - 1)) begin
          mode_d  = ModeRun;
          idle_d  = '0;
          blink_d = 1'b0;
        end else begin
          idle_d = idle_q + IdleW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q     <= ModeRun;
      idle_q     <= '0;
      blink_q    <= 1'b0;
      inc_hour_q <= 1'b0;
      inc_min_q  <= 1'b0;
      clr_sec_q  <= 1'b0;
    end else begin
      mode_q     <= mode_d;
      idle_q     <= idle_d;
      blink_q    <= blink_d;
      inc_hour_q <= inc_hour_d;
      inc_min_q  <= inc_min_d;
      clr_sec_q  <= clr_sec_d;
    end
  end

  assign bus.run_en     = (mode_q != ModeSetSec);
  assign bus.inc_hour   = inc_hour_q;
  assign bus.inc_min    = inc_min_q;
  assign bus.clr_sec    = clr_sec_q;
  assign bus.blank_hour = (mode_q == ModeSetHour) && blink_q;
  assign bus.blank_min  = (mode_q == ModeSetMin) && blink_q;
  assign bus.mode       = mode_q;

endmodule

// File: tb/tb_clock_set_controller.sv
// Directed bench for clock_set_controller (DEBOUNCE=4, IDLE=3, REPEAT 20/8 when enabled).
module tb_clock_set_controller;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  int   n_hour, n_min, n_sec, n_wide;
  logic prev_hour, prev_min, prev_sec;

  clock_set_controller_if dut_if ();

  clock_set_controller #(
    .DEBOUNCE_CYCLES(4),
    .IDLE_TIMEOUT_S (3)
`ifdef CLKSET_AUTOREPEAT_EN
    ,
    .REPEAT_DELAY   (20),
    .REPEAT_PERIOD  (8)
`endif
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(dut_if)
  );

  always #5 clk = ~clk;

  task automatic clear_counts();
    n_hour = 0; n_min = 0; n_sec = 0; n_wide = 0;
  endtask

  // One clock; sample 1 time unit after the edge and tally strobes.
  task automatic cycle();
    @(posedge clk);
    #1;
    if (dut_if.inc_hour) n_hour++;
    if (dut_if.inc_min)  n_min++;
    if (dut_if.clr_sec)  n_sec++;
    if ((dut_if.inc_hour && prev_hour) || (dut_if.inc_min && prev_min) ||
        (dut_if.clr_sec && prev_sec)) n_wide++;
    prev_hour = dut_if.inc_hour;
    prev_min  = dut_if.inc_min;
    prev_sec  = dut_if.clr_sec;
  endtask

  task automatic press_mode();
    dut_if.btn_mode_n = 1'b0;
    repeat (6) cycle();
    dut_if.btn_mode_n = 1'b1;
    repeat (8) cycle();
  endtask

  task automatic press_inc();
    dut_if.btn_inc_n = 1'b0;
    repeat (6) cycle();
    dut_if.btn_inc_n = 1'b1;
    repeat (8) cycle();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) cycle();
    vectors++;
    if (dut_if.run_en !== 1'b1) begin
      miscompares++; $display("FAIL reset_run_en: got %b want 1", dut_if.run_en);
    end
    vectors++;
    if (dut_if.mode !== 2'd0) begin
      miscompares++; $display("FAIL reset_mode: got %0d want 0", dut_if.mode);
    end
    vectors++;
    if ({dut_if.inc_hour, dut_if.inc_min, dut_if.clr_sec, dut_if.blank_hour, dut_if.blank_min}
        !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_strobes: got %b want 00000", {dut_if.inc_hour, dut_if.inc_min,
               dut_if.clr_sec, dut_if.blank_hour, dut_if.blank_min});
    end
    rst = 1'b0;
    repeat (3) cycle();
  endtask

  task automatic test_debounce();
    logic changed;
    int   first;
    changed = 1'b0;
    dut_if.btn_mode_n = 1'b0;
    repeat (3) begin cycle(); if (dut_if.mode !== 2'd0) changed = 1'b1; end
    dut_if.btn_mode_n = 1'b1;
    repeat (12) begin cycle(); if (dut_if.mode !== 2'd0) changed = 1'b1; end
    vectors++;
    if (changed !== 1'b0) begin
      miscompares++; $display("FAIL glitch_ignored: got mode change %b want 0", changed);
    end
    first = -1;
    dut_if.btn_mode_n = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      cycle();
      if (first < 0 && dut_if.mode === 2'd1) first = i;
    end
    dut_if.btn_mode_n = 1'b1;
    repeat (10) cycle();
    vectors++;
    if (first != 7) begin
      miscompares++; $display("FAIL press_latency: got %0d cycles want 7", first);
    end
  endtask

  task automatic test_inc_hour();
    clear_counts();
    repeat (3) press_inc();
    vectors++;
    if (n_hour != 3) begin
      miscompares++; $display("FAIL inc_hour_count: got %0d want 3", n_hour);
    end
    vectors++;
    if (n_min + n_sec != 0) begin
      miscompares++; $display("FAIL inc_hour_others: got %0d want 0", n_min + n_sec);
    end
    vectors++;
    if (n_wide != 0) begin
      miscompares++; $display("FAIL inc_hour_width: got %0d wide pulses want 0", n_wide);
    end
    vectors++;
    if (dut_if.mode !== 2'd1) begin
      miscompares++; $display("FAIL inc_hour_mode: got %0d want 1", dut_if.mode);
    end
  endtask

  task automatic test_simultaneous();
    clear_counts();
    dut_if.btn_mode_n = 1'b0;
    dut_if.btn_inc_n  = 1'b0;
    repeat (6) cycle();
    dut_if.btn_mode_n = 1'b1;
    dut_if.btn_inc_n  = 1'b1;
    repeat (8) cycle();
    vectors++;
    if (dut_if.mode !== 2'd2) begin
      miscompares++; $display("FAIL simul_mode: got %0d want 2", dut_if.mode);
    end
    vectors++;
    if (n_hour + n_min != 0) begin
      miscompares++; $display("FAIL simul_no_inc: got %0d strobes want 0", n_hour + n_min);
    end
  endtask

  task automatic test_timeout();
    logic [2:0] want_blank [3];
    logic [1:0] want_mode  [3];
    want_blank[0] = 3'd1; want_blank[1] = 3'd0; want_blank[2] = 3'd0;
    want_mode[0]  = 2'd2; want_mode[1]  = 2'd2; want_mode[2]  = 2'd0;
    for (int t = 0; t < 3; t++) begin
      dut_if.tick_1hz = 1'b1;
      cycle();
      dut_if.tick_1hz = 1'b0;
      vectors++;
      if (dut_if.blank_min !== want_blank[t][0] || dut_if.blank_hour !== 1'b0) begin
        miscompares++;
        $display("FAIL timeout_blank tick%0d: got min=%b hour=%b want min=%b hour=0", t + 1,
                 dut_if.blank_min, dut_if.blank_hour, want_blank[t][0]);
      end
      vectors++;
      if (dut_if.mode !== want_mode[t]) begin
        miscompares++;
        $display("FAIL timeout_mode tick%0d: got %0d want %0d", t + 1, dut_if.mode, want_mode[t]);
      end
      repeat (3) cycle();
    end
  endtask

  task automatic test_set_sec();
    repeat (3) press_mode();
    vectors++;
    if (dut_if.mode !== 2'd3 || dut_if.run_en !== 1'b0) begin
      miscompares++;
      $display("FAIL set_sec_enter: got mode=%0d run_en=%b want 3/0", dut_if.mode, dut_if.run_en);
    end
    clear_counts();
    press_inc();
    vectors++;
    if (n_sec != 1 || n_hour + n_min != 0) begin
      miscompares++;
      $display("FAIL set_sec_clr: got clr=%0d inc=%0d want 1/0", n_sec, n_hour + n_min);
    end
    press_mode();
    vectors++;
    if (dut_if.mode !== 2'd0 || dut_if.run_en !== 1'b1) begin
      miscompares++;
      $display("FAIL set_sec_exit: got mode=%0d run_en=%b want 0/1", dut_if.mode, dut_if.run_en);
    end
  endtask

  task automatic test_autorepeat();
    int want;
`ifdef CLKSET_AUTOREPEAT_EN
    want = 2 + (60 - 1 - 20) / 8;
`else
    want = 1;
`endif
    repeat (2) press_mode();
    clear_counts();
    dut_if.btn_inc_n = 1'b0;
    repeat (60) cycle();
    dut_if.btn_inc_n = 1'b1;
    repeat (10) cycle();
    vectors++;
    if (n_min != want || n_wide != 0) begin
      miscompares++;
      $display("FAIL autorepeat_count: got %0d (wide %0d) want %0d", n_min, n_wide, want);
    end
  endtask

  task automatic test_reset_mid();
    clear_counts();
    dut_if.btn_inc_n = 1'b0;
    repeat (8) cycle();
    vectors++;
    if (n_min != 1) begin
      miscompares++; $display("FAIL reset_mid_pre: got %0d inc_min want 1", n_min);
    end
    rst = 1'b1;
    cycle();
    vectors++;
    if (dut_if.mode !== 2'd0 || dut_if.inc_min !== 1'b0 || dut_if.inc_hour !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_edge: got mode=%0d inc_min=%b want 0/0", dut_if.mode,
               dut_if.inc_min);
    end
    rst = 1'b0;
    repeat (10) cycle();
    press_mode();
    clear_counts();
    repeat (30) cycle();
    vectors++;
    if (dut_if.mode !== 2'd1 || n_hour != 0) begin
      miscompares++;
      $display("FAIL reset_mid_held: got mode=%0d inc_hour=%0d want 1/0", dut_if.mode, n_hour);
    end
    dut_if.btn_inc_n = 1'b1;
    repeat (12) cycle();
    press_inc();
    vectors++;
    if (n_hour != 1) begin
      miscompares++; $display("FAIL reset_mid_repress: got %0d inc_hour want 1", n_hour);
    end
  endtask

  initial begin
    dut_if.btn_mode_n = 1'b1;
    dut_if.btn_inc_n  = 1'b1;
    dut_if.tick_1hz   = 1'b0;
    prev_hour = 1'b0; prev_min = 1'b0; prev_sec = 1'b0;
    clear_counts();
    test_reset();
    test_debounce();
    test_inc_hour();
    test_simultaneous();
    test_timeout();
    test_set_sec();
    test_autorepeat();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
